// File: rtl/uart_tx_stream.sv
// uart_tx_stream: serialises bytes from the peripheral-side FIFO read port onto
// a UART TX line. Frame = start, DATA_BITS (LSB first), optional parity, STOP_BITS.
// o_ready is asserted in IDLE and in the last cycle of the last stop bit, so a
// byte waiting at the FIFO is sent back-to-back with no idle gap.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_uart_tx,
    output logic                 o_busy,
    output logic                 o_frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state_q,  state_d;
    logic [BAUD_W-1:0]    baud_q,   baud_d;
    logic [BIT_W-1:0]     bit_q,    bit_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q,     tx_d;

    logic bit_end;
    logic last_stop;
    logic accept;

    // Handshake and status decode from state and counters only (never i_valid).
    always_comb begin
        bit_end      = (baud_q == BAUD_LAST);
        last_stop    = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
        o_ready      = (state_q == S_IDLE) || last_stop;
        accept       = i_valid && o_ready;
        o_frame_done = last_stop;
        o_busy       = (state_q != S_IDLE);
        o_uart_tx    = tx_q;
    end

    // Next-state logic: advance one bit each time the baud counter hits its
    // terminal value; an accept overrides everything and starts a new frame.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        if (accept) begin
            state_d  = S_START;
            baud_d   = '0;
            bit_d    = '0;
            shift_d  = i_data;
            parity_d = (PARITY == 1) ? ~(^i_data) : (^i_data);
            tx_d     = 1'b0;
        end
    end

    // State registers with synchronous active-low reset; line idles high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Testbench for uart_tx_stream. Four instances with CLKS_PER_BIT=4:
// 0 = 8N1, 1 = even parity, 2 = odd parity, 3 = two stop bits.
module tb_uart_tx_stream;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rstn [4];
    logic [7:0] din  [4];
    logic       vld  [4];
    logic       tx   [4];
    logic       rdy  [4];
    logic       busy [4];
    logic       done [4];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            uart_tx_stream #(
                .CLKS_PER_BIT(CPB),
                .DATA_BITS   (8),
                .PARITY      (gi == 1 ? 2 : (gi == 2 ? 1 : 0)),
                .STOP_BITS   (gi == 3 ? 2 : 1)
            ) u_dut (
                .i_clk       (clk),
                .i_rst_n     (rstn[gi]),
                .i_data      (din[gi]),
                .i_valid     (vld[gi]),
                .o_ready     (rdy[gi]),
                .o_uart_tx   (tx[gi]),
                .o_busy      (busy[gi]),
                .o_frame_done(done[gi])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic int par_mode(int k);
        return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
    endfunction

    function automatic int stop_cnt(int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int flen(int k);
        return (1 + 8 + ((par_mode(k) != 0) ? 1 : 0) + stop_cnt(k)) * CPB;
    endfunction

    // Expected line level r cycles into a frame carrying byte b.
    function automatic logic exp_bit(int k, logic [7:0] b, int r);
        int pos  = r / CPB;
        int ones = $countones(b);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (par_mode(k) != 0 && pos == 9)
            return (par_mode(k) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            rstn[k] = 1'b0; vld[k] = 1'b0; din[k] = 8'h00;
        end
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({tx[k], done[k], busy[k]} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_hold k=%0d got {tx,done,busy}=%b expected 100", k, {tx[k], done[k], busy[k]});
            end
            rstn[k] = 1'b1;
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if ({tx[k], rdy[k], done[k], busy[k]} !== 4'b1100) begin
                    miscompares++;
                    $display("FAIL idle k=%0d c=%0d got {tx,rdy,done,busy}=%b expected 1100", k, c, {tx[k], rdy[k], done[k], busy[k]});
                end
            end
        end
    endtask

    // Single frames on any instance: list of (instance, byte) pairs.
    task automatic test_frames(string name, int kl[$], logic [7:0] bl[$], int chg_at);
        for (int n = 0; n < kl.size(); n++) begin
            int k = kl[n];
            int f = flen(k);
            logic [7:0] b = bl[n];
            vectors++;
            if (rdy[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_ready_before k=%0d got %b expected 1", name, k, rdy[k]);
            end
            vld[k] = 1'b1; din[k] = b;
            tick();
            vld[k] = 1'b0; din[k] = ~b;
            for (int j = 0; j < f; j++) begin
                logic last = (j == f - 1);
                if (j == chg_at) din[k] = 8'hFF;
                vectors++;
                if ({tx[k], rdy[k], done[k], busy[k]} !== {exp_bit(k, b, j), last, last, 1'b1}) begin
                    miscompares++;
                    $display("FAIL %s k=%0d byte=%h j=%0d got {tx,rdy,done,busy}=%b expected %b", name, k, b, j,
                             {tx[k], rdy[k], done[k], busy[k]}, {exp_bit(k, b, j), last, last, 1'b1});
                end
                tick();
            end
            vectors++;
            if ({tx[k], rdy[k], done[k], busy[k]} !== 4'b1100) begin
                miscompares++;
                $display("FAIL %s_idle_after k=%0d got {tx,rdy,done,busy}=%b expected 1100", name, k, {tx[k], rdy[k], done[k], busy[k]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q [3];
        int f = flen(0);
        int pulses = 0;
        q[0] = 8'h00; q[1] = 8'hFF; q[2] = 8'($urandom);
        vld[0] = 1'b1; din[0] = q[0];
        tick();
        for (int j = 0; j < 3 * f; j++) begin
            int fr = j / f;
            int r  = j % f;
            logic last = (r == f - 1);
            if (r == 0) begin
                if (fr < 2) din[0] = q[fr+1];
                else        vld[0] = 1'b0;
            end
            vectors++;
            if ({tx[0], rdy[0], done[0], busy[0]} !== {exp_bit(0, q[fr], r), last, last, 1'b1}) begin
                miscompares++;
                $display("FAIL b2b j=%0d got {tx,rdy,done,busy}=%b expected %b", j,
                         {tx[0], rdy[0], done[0], busy[0]}, {exp_bit(0, q[fr], r), last, last, 1'b1});
            end
            if (done[0] === 1'b1) pulses++;
            tick();
        end
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL b2b_pulses got %0d expected 3", pulses);
        end
        vectors++;
        if ({tx[0], rdy[0], done[0], busy[0]} !== 4'b1100) begin
            miscompares++;
            $display("FAIL b2b_idle got {tx,rdy,done,busy}=%b expected 1100", {tx[0], rdy[0], done[0], busy[0]});
        end
    endtask

    task automatic test_reset_mid();
        int kl[$];
        logic [7:0] bl[$];
        logic [7:0] b = 8'h55;
        vld[0] = 1'b1; din[0] = b;
        tick();
        vld[0] = 1'b0;
        for (int j = 0; j < 14; j++) begin
            vectors++;
            if (tx[0] !== exp_bit(0, b, j)) begin
                miscompares++;
                $display("FAIL rstmid_line j=%0d got %b expected %b", j, tx[0], exp_bit(0, b, j));
            end
            if (j < 13) tick();
        end
        rstn[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if ({tx[0], done[0], busy[0]} !== 3'b100) begin
                miscompares++;
                $display("FAIL rstmid_hold c=%0d got {tx,done,busy}=%b expected 100", c, {tx[0], done[0], busy[0]});
            end
        end
        rstn[0] = 1'b1;
        tick();
        vectors++;
        if ({tx[0], rdy[0], done[0], busy[0]} !== 4'b1100) begin
            miscompares++;
            $display("FAIL rstmid_release got {tx,rdy,done,busy}=%b expected 1100", {tx[0], rdy[0], done[0], busy[0]});
        end
        kl.push_back(0); bl.push_back(8'h81);
        test_frames("after_rst", kl, bl, -1);
    endtask

    initial begin
        int kl[$];
        logic [7:0] bl[$];
        for (int k = 0; k < 4; k++) begin
            rstn[k] = 1'b0; vld[k] = 1'b0; din[k] = 8'h00;
        end
        test_reset();

        kl = '{0, 0, 0, 0};
        bl = '{8'hA5, 8'($urandom), 8'($urandom), 8'($urandom)};
        test_frames("8n1", kl, bl, -1);

        test_back_to_back();

        kl = '{1, 2, 2, 1, 2};
        bl = '{8'hA5, 8'hA5, 8'h01, 8'($urandom), 8'($urandom)};
        test_frames("parity", kl, bl, -1);

        kl = '{3, 3};
        bl = '{8'h3C, 8'($urandom)};
        test_frames("stop2", kl, bl, 10);

        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
